ddc_iq_capture: RTL

Parametrised, multi-channel I/Q snapshot engine for the RX DDC outputs. It watches one selected DDC output stream, discards a programmable number of settling samples, then captures a programmable number of I/Q pairs into an on-chip buffer. The host reads the buffer back through a simple RAM-style port. The block also records the peak absolute sample value seen during the capture. It sits alongside the DDC channels as a never-stalling tap, so DDC throughput is unaffected.

---
 rtl/ddc_iq_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ddc_iq_capture.sv
// I/Q snapshot engine: taps one DDC output stream, drops settling beats, then
// captures a burst of {Q,I} pairs into block RAM while tracking the peak magnitude.
module ddc_iq_capture #(
    parameter int NCHAN = 2,
    parameter int SAMPW = 24,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH),
    localparam int CSW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                     aclk,
    input  logic                     rst,
    input  logic [NCHAN*2*SAMPW-1:0] s_axis_tdata,
    input  logic [NCHAN-1:0]         s_axis_tvalid,
    output logic [NCHAN-1:0]         s_axis_tready,
    input  logic [CSW-1:0]           chan_sel,
    input  logic [15:0]              discard_count,
    input  logic [AW:0]              capture_count,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [AW:0]              wr_count,
    output logic [SAMPW-2:0]         peak_abs,
    input  logic [AW-1:0]            rd_addr,
    input  logic                     rd_en,
    output logic [2*SAMPW-1:0]       rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CSW-1:0]     chan_q, chan_d;
    logic [15:0]        disc_lim_q, disc_lim_d;
    logic [15:0]        disc_cnt_q, disc_cnt_d;
    logic [AW:0]        cap_lim_q, cap_lim_d;
    logic [AW:0]        wr_count_q, wr_count_d;
    logic [SAMPW-2:0]   peak_q, peak_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*SAMPW-1:0] mem [DEPTH];
    logic [2*SAMPW-1:0] rd_data_q;

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [2*SAMPW-1:0]  wr_data;

    logic [NCHAN-1:0]    chan_hit;
    logic [2*SAMPW-1:0]  chan_data [NCHAN];
    logic                sel_valid;
    logic [2*SAMPW-1:0]  sel_data;
    logic [SAMPW-2:0]    abs_i, abs_q, peak_upd;
    logic [AW:0]         cap_eff;

    // The tap never back-pressures the DDC, even while held in reset.
    assign s_axis_tready = '1;

    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            assign chan_data[gi] = s_axis_tdata[gi*2*SAMPW +: 2*SAMPW];
            assign chan_hit[gi]  = (chan_q == CSW'(gi));
        end
    endgenerate

    // A latched channel index beyond NCHAN selects nothing, so no beats arrive.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int n = 0; n < NCHAN; n++) begin
            if (chan_hit[n]) begin
                sel_valid = s_axis_tvalid[n];
                sel_data  = chan_data[n];
            end
        end
    end

    // Magnitude with the most negative code saturated to the largest positive one.
    function automatic logic [SAMPW-2:0] abs_sat(input logic [SAMPW-1:0] x);
        if (!x[SAMPW-1]) begin
            return x[SAMPW-2:0];
        end else if (x[SAMPW-2:0] == '0) begin
            return '1;
        end else begin
            return ~x[SAMPW-2:0] + (SAMPW-1)'(1);
        end
    endfunction

    always_comb begin
        abs_i    = abs_sat(sel_data[SAMPW-1:0]);
        abs_q    = abs_sat(sel_data[2*SAMPW-1:SAMPW]);
        peak_upd = peak_q;
        if (abs_i > peak_upd) begin
            peak_upd = abs_i;
        end
        if (abs_q > peak_upd) begin
            peak_upd = abs_q;
        end
    end

    always_comb begin
        if (capture_count == '0 || capture_count > (AW+1)'(DEPTH)) begin
            cap_eff = (AW+1)'(DEPTH);
        end else begin
            cap_eff = capture_count;
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        disc_lim_d = disc_lim_q;
        disc_cnt_d = disc_cnt_q;
        cap_lim_d  = cap_lim_q;
        wr_count_d = wr_count_q;
        peak_d     = peak_q;
        wr_en      = 1'b0;
        wr_addr    = wr_count_q[AW-1:0];
        wr_data    = sel_data;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        chan_d     = chan_sel;
                        disc_lim_d = discard_count;
                        cap_lim_d  = cap_eff;
                        disc_cnt_d = '0;
                        wr_count_d = '0;
                        peak_d     = '0;
                        state_d    = (discard_count == '0) ? ST_CAPTURE : ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (sel_valid) begin
                        disc_cnt_d = disc_cnt_q + 16'd1;
                        if (disc_cnt_d == disc_lim_q) begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sel_valid) begin
                        wr_en      = 1'b1;
                        wr_count_d = wr_count_q + (AW+1)'(1);
                        peak_d     = peak_upd;
                        if (wr_count_d == cap_lim_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_DISCARD) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            disc_lim_q <= '0;
            disc_cnt_q <= '0;
            cap_lim_q  <= '0;
            wr_count_q <= '0;
            peak_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            disc_lim_q <= disc_lim_d;
            disc_cnt_q <= disc_cnt_d;
            cap_lim_q  <= cap_lim_d;
            wr_count_q <= wr_count_d;
            peak_q     <= peak_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Buffer write port; contents deliberately survive reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read gives read-before-write on an address collision.
    always_ff @(posedge aclk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign peak_abs = peak_q;
    assign rd_data  = rd_data_q;

endmodule
